// File: rtl/core_alu_pkg.sv
// Shared RV32 ALU constants and the request payload struct used by core_alu and core_alu_arb.
// Includes the integer-op helper shared by the register and immediate forms.
package core_alu_pkg;

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_ALT = 7'b0100000;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [6:0]  funct7;
      logic [2:0]  funct3;
      logic [31:0] num1;
      logic [31:0] num2;
      logic [31:0] pc;
      logic [31:0] imm;
   } alu_req_t;

   // alt selects SUB for F3_ADD and arithmetic shift for F3_SR.
   function automatic logic [31:0] alu_calc(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (f3)
         F3_ADD:  r = alt ? (a - b) : (a + b);
         F3_SLL:  r = a << b[4:0];
         F3_SLT:  r = {31'b0, $signed(a) < $signed(b)};
         F3_SLTU: r = {31'b0, a < b};
         F3_XOR:  r = a ^ b;
         F3_SR:   r = alt ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
         F3_OR:   r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/core_alu_arb_if.sv
// Request/response bundle of core_alu_arb; names carry the arbiter's i_/o_ direction.
// o_grant_cnt exists only when CORE_ALU_ARB_STATS_EN is defined.
interface core_alu_arb_if #(
   parameter int NUM_REQ = 2,
   parameter int STATS_W = 16
);
   localparam int ID_W = $clog2(NUM_REQ);

   // Requests: k fires on i_req_valid[k] & o_req_ready[k]; valid and payload are held until fire.
   // Response: consumed on o_rsp_valid & i_rsp_ready; outputs stay stable while stalled.
   logic [NUM_REQ-1:0]    i_req_valid;
   logic [NUM_REQ-1:0]    o_req_ready;
   logic [NUM_REQ*7-1:0]  i_req_opcode;
   logic [NUM_REQ*7-1:0]  i_req_funct7;
   logic [NUM_REQ*3-1:0]  i_req_funct3;
   logic [NUM_REQ*32-1:0] i_req_num1;
   logic [NUM_REQ*32-1:0] i_req_num2;
   logic [NUM_REQ*32-1:0] i_req_pc;
   logic [NUM_REQ*32-1:0] i_req_imm;
   logic                  o_rsp_valid;
   logic                  i_rsp_ready;
   logic [ID_W-1:0]       o_rsp_id;
   logic [31:0]           o_rsp_res;
   logic                  o_rsp_branch;
   logic [31:0]           o_rsp_target;
`ifdef CORE_ALU_ARB_STATS_EN
   logic [NUM_REQ*STATS_W-1:0] o_grant_cnt;
`endif

   modport slave (
      input  i_req_valid, i_req_opcode, i_req_funct7, i_req_funct3,
      input  i_req_num1, i_req_num2, i_req_pc, i_req_imm, i_rsp_ready,
`ifdef CORE_ALU_ARB_STATS_EN
      output o_grant_cnt,
`endif
      output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_res, o_rsp_branch, o_rsp_target
   );

   modport master (
      output i_req_valid, i_req_opcode, i_req_funct7, i_req_funct3,
      output i_req_num1, i_req_num2, i_req_pc, i_req_imm, i_rsp_ready,
`ifdef CORE_ALU_ARB_STATS_EN
      input  o_grant_cnt,
`endif
      input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_res, o_rsp_branch, o_rsp_target
   );

endinterface

// File: rtl/core_alu.sv
// Combinational RV32I integer ALU: result, branch/jump decision and target.
module core_alu
   import core_alu_pkg::*;
(
   input  alu_req_t    i_req,
   output logic [31:0] o_res,
   output logic        o_branch,
   output logic [31:0] o_target
);

   logic        alt;
   logic        taken;
   logic [31:0] jalr_sum;

   assign alt      = (i_req.funct7 == F7_ALT);
   assign jalr_sum = i_req.num1 + i_req.imm;

   always_comb begin
      taken = 1'b0;
      case (i_req.funct3)
         F3_BEQ:  taken = (i_req.num1 == i_req.num2);
         F3_BNE:  taken = (i_req.num1 != i_req.num2);
         F3_BLT:  taken = ($signed(i_req.num1) <  $signed(i_req.num2));
         F3_BGE:  taken = ($signed(i_req.num1) >= $signed(i_req.num2));
         F3_BLTU: taken = (i_req.num1 <  i_req.num2);
         F3_BGEU: taken = (i_req.num1 >= i_req.num2);
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      o_res    = '0;
      o_branch = 1'b0;
      o_target = '0;
      case (i_req.opcode)
         OP_OP:    o_res = alu_calc(i_req.funct3, alt, i_req.num1, i_req.num2);
         // Only SRAI has an alternate form among the immediate ops.
         OP_IMM:   o_res = alu_calc(i_req.funct3, alt && (i_req.funct3 == F3_SR),
                                    i_req.num1, i_req.imm);
         OP_LUI:   o_res = i_req.imm;
         OP_AUIPC: o_res = i_req.pc + i_req.imm;
         OP_JAL: begin
            o_res    = i_req.pc + 32'd4;
            o_branch = 1'b1;
            o_target = i_req.pc + i_req.imm;
         end
         OP_JALR: begin
            o_res    = i_req.pc + 32'd4;
            o_branch = 1'b1;
            o_target = jalr_sum & ~32'd1;
         end
         OP_BRANCH: begin
            o_branch = taken;
            o_target = i_req.pc + i_req.imm;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/core_rr_arb.sv
// Round-robin arbiter: one-hot grant searching upward from last winner + 1; pointer moves only when i_en.
module core_rr_arb #(
   parameter  int N  = 2,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [N-1:0]  i_req,
   input  logic          i_en,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx
);

   logic [IW-1:0] last_q, last_d;
   logic [IW-1:0] cand_idx;
   logic          found;
   int            cand;

   always_comb begin
      o_gnt    = '0;
      o_idx    = '0;
      found    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int i = 1; i <= N; i++) begin
         cand = int'(last_q) + i;
         if (cand >= N) cand = cand - N;
         cand_idx = IW'(cand);
         if (!found && i_req[cand_idx]) begin
            found        = 1'b1;
            o_gnt        = '0;
            o_gnt[cand_idx] = 1'b1;
            o_idx        = cand_idx;
         end
      end
   end

   assign last_d = (i_en && found) ? o_idx : last_q;

   // Reset to N-1 so requester 0 is searched first.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) last_q <= IW'(N - 1);
      else       last_q <= last_d;
   end

endmodule

// File: rtl/core_alu_arb.sv
// Round-robin sharing of one core_alu between NUM_REQ requesters with a one-entry tagged response buffer.
// Optional per-requester saturating grant counters under CORE_ALU_ARB_STATS_EN.
module core_alu_arb
   import core_alu_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int STATS_W = 16
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_flush,
   core_alu_arb_if.slave  bus
);

   localparam int ID_W = $clog2(NUM_REQ);

   logic               accept;
   logic               fire;
   logic [NUM_REQ-1:0] gnt;
   logic [NUM_REQ-1:0] req_ready;
   logic [ID_W-1:0]    gnt_idx;
   alu_req_t           alu_req;
   logic [31:0]        alu_res, alu_target;
   logic               alu_branch;

   logic               rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
   logic [31:0]        rsp_res_q, rsp_res_d;
   logic               rsp_branch_q, rsp_branch_d;
   logic [31:0]        rsp_target_q, rsp_target_d;

   // The slot frees in the same cycle it drains, so a new op can enter back-to-back.
   assign accept    = !i_flush && (!rsp_valid_q || bus.i_rsp_ready);
   assign req_ready = gnt & {NUM_REQ{accept}};
   assign fire      = |req_ready;

   core_rr_arb #(.N(NUM_REQ)) u_arb (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_req (bus.i_req_valid),
      .i_en  (accept),
      .o_gnt (gnt),
      .o_idx (gnt_idx)
   );

   always_comb begin
      alu_req = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt[k]) begin
            alu_req.opcode = bus.i_req_opcode[k*7 +: 7];
            alu_req.funct7 = bus.i_req_funct7[k*7 +: 7];
            alu_req.funct3 = bus.i_req_funct3[k*3 +: 3];
            alu_req.num1   = bus.i_req_num1[k*32 +: 32];
            alu_req.num2   = bus.i_req_num2[k*32 +: 32];
            alu_req.pc     = bus.i_req_pc[k*32 +: 32];
            alu_req.imm    = bus.i_req_imm[k*32 +: 32];
         end
      end
   end

   core_alu u_alu (
      .i_req    (alu_req),
      .o_res    (alu_res),
      .o_branch (alu_branch),
      .o_target (alu_target)
   );

   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_res_d    = rsp_res_q;
      rsp_branch_d = rsp_branch_q;
      rsp_target_d = rsp_target_q;
      if (fire) begin
         rsp_valid_d  = 1'b1;
         rsp_id_d     = gnt_idx;
         rsp_res_d    = alu_res;
         rsp_branch_d = alu_branch;
         rsp_target_d = alu_target;
      end else if (i_flush || (rsp_valid_q && bus.i_rsp_ready)) begin
         rsp_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_res_q    <= '0;
         rsp_branch_q <= 1'b0;
         rsp_target_q <= '0;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_res_q    <= rsp_res_d;
         rsp_branch_q <= rsp_branch_d;
         rsp_target_q <= rsp_target_d;
      end
   end

   assign bus.o_req_ready  = req_ready;
   assign bus.o_rsp_valid  = rsp_valid_q;
   assign bus.o_rsp_id     = rsp_id_q;
   assign bus.o_rsp_res    = rsp_res_q;
   assign bus.o_rsp_branch = rsp_branch_q;
   assign bus.o_rsp_target = rsp_target_q;

`ifdef CORE_ALU_ARB_STATS_EN
   logic [NUM_REQ-1:0][STATS_W-1:0] cnt_q, cnt_d;

   // Counters saturate rather than wrap; flush leaves them alone.
   always_comb begin
      cnt_d = cnt_q;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (req_ready[k] && (cnt_q[k] != {STATS_W{1'b1}})) cnt_d[k] = cnt_q[k] + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign bus.o_grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_core_alu_arb.sv
// Self-checking bench for core_alu_arb: directed scenarios plus a random phase against a reference model.
// Build with CORE_ALU_ARB_STATS_EN to also check the saturating grant counters.
module tb_core_alu_arb;
   import core_alu_pkg::*;

   localparam int NUM_REQ = 2;
   localparam int STATS_W = 4;
   localparam int ID_W    = 1;
   localparam int RW      = ID_W + 1 + 32 + 32;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   core_alu_arb_if #(.NUM_REQ(NUM_REQ), .STATS_W(STATS_W)) bus ();

   core_alu_arb #(.NUM_REQ(NUM_REQ), .STATS_W(STATS_W)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_flush (flush),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: returns {branch, target, res}.
   function automatic logic [64:0] ref_alu(input logic [6:0] op, input logic [6:0] f7,
                                           input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] pc,
                                           input logic [31:0] imm);
      logic [31:0] r, t, y;
      logic        br, sub;
      r = 0; t = 0; br = 0;
      sub = (f7 == 7'h20);
      y = (op == OP_OP) ? b : imm;
      if (op == OP_OP || op == OP_IMM) begin
         case (f3)
            3'd0: r = (op == OP_OP && sub) ? a - y : a + y;
            3'd1: r = a << y[4:0];
            3'd2: r = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: r = (a < y) ? 32'd1 : 32'd0;
            3'd4: r = a ^ y;
            3'd5: r = sub ? $unsigned($signed(a) >>> y[4:0]) : a >> y[4:0];
            3'd6: r = a | y;
            default: r = a & y;
         endcase
      end else if (op == OP_LUI) r = imm;
      else if (op == OP_AUIPC) r = pc + imm;
      else if (op == OP_JAL) begin r = pc + 4; br = 1; t = pc + imm; end
      else if (op == OP_JALR) begin r = pc + 4; br = 1; t = (a + imm) & 32'hFFFF_FFFE; end
      else if (op == OP_BRANCH) begin
         t = pc + imm;
         case (f3)
            3'd0: br = (a == b);
            3'd1: br = (a != b);
            3'd4: br = ($signed(a) < $signed(b));
            3'd5: br = !($signed(a) < $signed(b));
            3'd6: br = (a < b);
            3'd7: br = !(a < b);
            default: br = 0;
         endcase
      end
      return {br, t, r};
   endfunction

   task automatic set_req(input int k, input logic [6:0] op, input logic [6:0] f7,
                          input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [31:0] imm);
      bus.i_req_opcode[k*7 +: 7]  = op;
      bus.i_req_funct7[k*7 +: 7]  = f7;
      bus.i_req_funct3[k*3 +: 3]  = f3;
      bus.i_req_num1[k*32 +: 32]  = a;
      bus.i_req_num2[k*32 +: 32]  = b;
      bus.i_req_pc[k*32 +: 32]    = pc;
      bus.i_req_imm[k*32 +: 32]   = imm;
      bus.i_req_valid[k]          = 1'b1;
   endtask

   task automatic clr_req(input int k);
      bus.i_req_valid[k] = 1'b0;
   endtask

   task automatic rand_req(input int k);
      logic [6:0]  ops[7];
      logic [2:0]  brf3[6];
      logic [6:0]  op, f7;
      logic [2:0]  f3;
      logic [31:0] a, b;
      ops  = '{OP_OP, OP_IMM, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
      brf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      op = ops[$urandom_range(0, 6)];
      f3 = (op == OP_BRANCH) ? brf3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
      f7 = ((op == OP_OP || op == OP_IMM) && (f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1)
           ? 7'h20 : 7'h00;
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? a : $urandom;
      set_req(k, op, f7, f3, a, b, $urandom & 32'hFFFF_FFFC, 32'($signed(12'($urandom))));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard/model, evaluated on the falling edge while inputs are stable.
   logic [RW-1:0]      exp_q[$];
   logic [RW-1:0]      m_data;
   logic               m_vld;
   int                 m_last;
   int                 g, c;
   bit                 pending;
   logic               acc;
   logic [NUM_REQ-1:0] exp_rdy;
`ifdef CORE_ALU_ARB_STATS_EN
   logic [STATS_W-1:0] m_cnt[NUM_REQ];
`endif

   always @(negedge clk) begin
      if (rst) begin
         m_last = NUM_REQ - 1; m_vld = 0; m_data = '0; pending = 0;
         exp_q.delete();
`ifdef CORE_ALU_ARB_STATS_EN
         for (int k = 0; k < NUM_REQ; k++) m_cnt[k] = '0;
`endif
      end else begin
         if (pending) begin
            if (exp_q.size() == 0) check("sb_empty", 1, 0);
            else m_data = exp_q.pop_front();
            pending = 0;
         end
         check("rsp_valid", bus.o_rsp_valid, m_vld);
         check("rsp_data", {bus.o_rsp_id, bus.o_rsp_branch, bus.o_rsp_target, bus.o_rsp_res}, m_data);
         acc = !flush && (!m_vld || bus.i_rsp_ready);
         g = -1;
         for (int i = 1; i <= NUM_REQ; i++) begin
            c = (m_last + i) % NUM_REQ;
            if (g < 0 && bus.i_req_valid[c]) g = c;
         end
         exp_rdy = '0;
         if (acc && g >= 0) exp_rdy[g] = 1'b1;
         check("req_ready", bus.o_req_ready, exp_rdy);
`ifdef CORE_ALU_ARB_STATS_EN
         for (int k = 0; k < NUM_REQ; k++)
            check("grant_cnt", bus.o_grant_cnt[k*STATS_W +: STATS_W], m_cnt[k]);
`endif
         if (acc && g >= 0) begin
            exp_q.push_back({g[ID_W-1:0],
                             ref_alu(bus.i_req_opcode[g*7 +: 7], bus.i_req_funct7[g*7 +: 7],
                                     bus.i_req_funct3[g*3 +: 3], bus.i_req_num1[g*32 +: 32],
                                     bus.i_req_num2[g*32 +: 32], bus.i_req_pc[g*32 +: 32],
                                     bus.i_req_imm[g*32 +: 32])});
            m_last = g; m_vld = 1; pending = 1;
`ifdef CORE_ALU_ARB_STATS_EN
            if (m_cnt[g] != '1) m_cnt[g] = m_cnt[g] + 1'b1;
`endif
         end else if (flush || (m_vld && bus.i_rsp_ready)) begin
            m_vld = 0;
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"},  bus.o_rsp_valid,  0);
      check({tag, "_id"},     bus.o_rsp_id,     0);
      check({tag, "_res"},    bus.o_rsp_res,    0);
      check({tag, "_branch"}, bus.o_rsp_branch, 0);
      check({tag, "_target"}, bus.o_rsp_target, 0);
      check({tag, "_ready"},  bus.o_req_ready,  0);
   endtask

   logic [NUM_REQ-1:0] fired;

   initial begin
      rst = 1'b0; flush = 1'b0;
      bus.i_rsp_ready = 1'b0; bus.i_req_valid = '0;
      bus.i_req_opcode = '0; bus.i_req_funct7 = '0; bus.i_req_funct3 = '0;
      bus.i_req_num1 = '0; bus.i_req_num2 = '0; bus.i_req_pc = '0; bus.i_req_imm = '0;
      #1 rst = 1'b1;
      #1 check_all_zero("reset");
      tick(); tick(); rst = 1'b0;

      // ADD 5+7 from requester 0
      bus.i_rsp_ready = 1'b1;
      set_req(0, OP_OP, 7'h00, F3_ADD, 32'd5, 32'd7, 32'd0, 32'd0);
      @(negedge clk); check("t1_ready", bus.o_req_ready, 2'b01);
      tick(); clr_req(0);
      @(negedge clk);
      check("t1_valid", bus.o_rsp_valid, 1); check("t1_id", bus.o_rsp_id, 0);
      check("t1_res", bus.o_rsp_res, 32'd12); check("t1_branch", bus.o_rsp_branch, 0);

      // Alternation after reset
      tick(); rst = 1'b1; tick(); rst = 1'b0;
      set_req(0, OP_OP, 7'h00, F3_ADD, 32'd1, 32'd1, 32'd0, 32'd0);
      set_req(1, OP_IMM, 7'h00, F3_XOR, 32'h0000_F0F0, 32'd0, 32'd0, 32'h0000_00FF);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t2_grant", bus.o_req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
         if (i > 0) check("t2_id", bus.o_rsp_id, (i % 2 == 0) ? 1 : 0);
         tick();
      end

      // Backpressure for three cycles, then drain and regrant together
      bus.i_rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t3_ready", bus.o_req_ready, 2'b00);
         check("t3_valid", bus.o_rsp_valid, 1);
         check("t3_id", bus.o_rsp_id, 1);
         check("t3_res", bus.o_rsp_res, 32'h0000_F00F);
      end
      @(posedge clk); #1 bus.i_rsp_ready = 1'b1;
      @(negedge clk); check("t3_regrant", bus.o_req_ready, 2'b01);
      tick();

      // BEQ taken / not taken from requester 1
      clr_req(0); clr_req(1);
      set_req(1, OP_BRANCH, 7'h00, F3_BEQ, 32'd3, 32'd3, 32'h100, 32'd8);
      @(negedge clk); check("t4_ready", bus.o_req_ready, 2'b10);
      tick();
      set_req(1, OP_BRANCH, 7'h00, F3_BEQ, 32'd3, 32'd4, 32'h100, 32'd8);
      @(negedge clk);
      check("t4_id", bus.o_rsp_id, 1); check("t4_branch", bus.o_rsp_branch, 1);
      check("t4_target", bus.o_rsp_target, 32'h108);
      tick();

      // Flush while stalled, with requester 0 waiting
      clr_req(1);
      set_req(0, OP_OP, 7'h00, F3_OR, 32'hA0, 32'h0B, 32'd0, 32'd0);
      bus.i_rsp_ready = 1'b0; flush = 1'b1;
      @(negedge clk);
      check("t4b_branch", bus.o_rsp_branch, 0); check("t4b_target", bus.o_rsp_target, 32'h108);
      check("t5_ready", bus.o_req_ready, 2'b00);
      tick(); flush = 1'b0;
      @(negedge clk);
      check("t5_valid", bus.o_rsp_valid, 0); check("t5_regrant", bus.o_req_ready, 2'b01);
      tick(); clr_req(0);
      @(negedge clk);
      check("t5_rsp_id", bus.o_rsp_id, 0); check("t5_rsp_res", bus.o_rsp_res, 32'hAB);

      // Flush with the consumer ready still suppresses the grant
      @(posedge clk); #1;
      bus.i_rsp_ready = 1'b1; flush = 1'b1;
      set_req(1, OP_LUI, 7'h00, 3'd0, 32'd0, 32'd0, 32'd0, 32'h1234_5000);
      @(negedge clk); check("t5b_ready", bus.o_req_ready, 2'b00);
      tick(); flush = 1'b0;
      @(negedge clk);
      check("t5b_valid", bus.o_rsp_valid, 0); check("t5b_regrant", bus.o_req_ready, 2'b10);
      tick(); clr_req(1);
      @(negedge clk); check("t5b_res", bus.o_rsp_res, 32'h1234_5000);

      // Random traffic; requesters hold valid until fired
      tick();
      for (int n = 0; n < 400; n++) begin
         @(negedge clk); fired = bus.i_req_valid & bus.o_req_ready;
         tick();
         for (int k = 0; k < NUM_REQ; k++) begin
            if (fired[k] || !bus.i_req_valid[k]) begin
               if ($urandom_range(0, 3) != 0) rand_req(k);
               else clr_req(k);
            end
         end
         bus.i_rsp_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 15) == 0);
      end
      tick();
      clr_req(0); clr_req(1); flush = 1'b0; bus.i_rsp_ready = 1'b1;
      tick(); tick();
`ifdef CORE_ALU_ARB_STATS_EN
      @(negedge clk);
      check("sat_cnt0", bus.o_grant_cnt[0 +: STATS_W], 4'hF);
      check("sat_cnt1", bus.o_grant_cnt[STATS_W +: STATS_W], 4'hF);
      tick();
`endif

      // Asynchronous reset while a response is held
      bus.i_rsp_ready = 1'b0;
      set_req(0, OP_LUI, 7'h00, 3'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_F000);
      tick(); clr_req(0);
      @(negedge clk); check("t6_pre_res", bus.o_rsp_res, 32'hFFFF_F000);
      #2 rst = 1'b1;
      #1 check_all_zero("t6_async");
`ifdef CORE_ALU_ARB_STATS_EN
      check("t6_cnt", bus.o_grant_cnt, 0);
`endif
      tick(); tick(); rst = 1'b0;
      bus.i_rsp_ready = 1'b1;
      set_req(0, OP_OP, 7'h00, F3_ADD, 32'd2, 32'd3, 32'd0, 32'd0);
      set_req(1, OP_OP, 7'h00, F3_ADD, 32'd4, 32'd5, 32'd0, 32'd0);
      @(negedge clk); check("t6_prio", bus.o_req_ready, 2'b01);
      tick(); clr_req(0); clr_req(1);
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
